// File: rtl/mul_accumulate_seq_pkg.sv
// Shared Q8.7 constants, saturation limits and controller state encoding
// for the multiply-accumulate sequencer.
package mul_accumulate_seq_pkg;

    localparam int DATA_W = 16;
    localparam int FRAC_W = 7;

    localparam logic signed [DATA_W-1:0] SAT_MAX = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] SAT_MIN = 16'sh8000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_CLR,
        WAIT_DONE,
        ACCUM,
        DONE
    } state_t;

endpackage

// File: rtl/mul_accumulate_seq_sat_adder16.sv
// 16-bit signed adder with overflow detect; clamps to the Q8.7 limits when
// MAC_SATURATE_EN is defined, otherwise wraps modulo 2^16.
module sat_adder16
    import mul_accumulate_seq_pkg::*;
(
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] sum,
    output logic                     overflow
);

    logic signed [DATA_W:0] sum_wide;

`ifdef MAC_SATURATE_EN
    // Bit 16 of the widened sum carries the true sign of the result.
    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [DATA_W:0] s);
        if (s[DATA_W] != s[DATA_W-1]) begin
            return s[DATA_W] ? SAT_MIN : SAT_MAX;
        end
        return s[DATA_W-1:0];
    endfunction
`endif

    always_comb begin
        sum_wide = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        overflow = sum_wide[DATA_W] ^ sum_wide[DATA_W-1];
`ifdef MAC_SATURATE_EN
        sum      = saturate(sum_wide);
`else
        sum      = sum_wide[DATA_W-1:0];
`endif
    end

endmodule

// File: rtl/mul_accumulate_seq.sv
// Sequencer that feeds operand pairs to an external Booth multiplier and sums
// the Q8.7 products; MAC_SATURATE_EN selects saturating instead of wrapping.
module mul_accumulate_seq
    import mul_accumulate_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic              in_last,
    input  logic              clear,
    output logic              mul_start,
    output logic [DATA_W-1:0] mul_multiplicand,
    output logic [DATA_W-1:0] mul_multiplier,
    input  logic [DATA_W-1:0] mul_result,
    input  logic              mul_overflow,
    input  logic              mul_finish,
    output logic [DATA_W-1:0] acc_out,
    output logic              acc_valid,
    output logic              overflow_flag,
    output logic              busy
);

    state_t state, state_next;

    logic signed [DATA_W-1:0] a_p0, b_p0;
    logic                     last_p0;
    logic signed [DATA_W-1:0] prod_sel, prod_p1;
    logic                     prod_ovf_p1;
    logic signed [DATA_W-1:0] acc, sum;
    logic                     add_ovf;
    logic                     transfer;

    assign in_ready         = (state == IDLE);
    assign busy             = (state != IDLE);
    assign mul_start        = (state == ISSUE);
    assign acc_valid        = (state == DONE);
    assign transfer         = in_valid && in_ready;
    assign mul_multiplicand = a_p0;
    assign mul_multiplier   = b_p0;
    assign acc_out          = acc;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (in_valid) state_next = ISSUE;
            ISSUE:     state_next = WAIT_CLR;
            // A finish still high from the previous product must fall first.
            WAIT_CLR:  if (!mul_finish) state_next = WAIT_DONE;
            WAIT_DONE: if (mul_finish) state_next = ACCUM;
            ACCUM:     state_next = last_p0 ? DONE : IDLE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Stage p0: operands held from transfer until the product is captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_p0    <= '0;
            b_p0    <= '0;
            last_p0 <= 1'b0;
        end else if (transfer) begin
            a_p0    <= in_a;
            b_p0    <= in_b;
            last_p0 <= in_last;
        end
    end

`ifdef MAC_SATURATE_EN
    function automatic logic signed [DATA_W-1:0] sat_product(
        input logic signed [DATA_W-1:0] res,
        input logic                     ovf,
        input logic                     neg
    );
        if (ovf) return neg ? SAT_MIN : SAT_MAX;
        return res;
    endfunction

    assign prod_sel = sat_product(mul_result, mul_overflow, a_p0[DATA_W-1] ^ b_p0[DATA_W-1]);
`else
    assign prod_sel = mul_result;
`endif

    // Stage p1: product captured when the multiplier signals finish.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prod_p1     <= '0;
            prod_ovf_p1 <= 1'b0;
        end else if (state == WAIT_DONE && mul_finish) begin
            prod_p1     <= prod_sel;
            prod_ovf_p1 <= mul_overflow;
        end
    end

    sat_adder16 u_add (
        .a        (acc),
        .b        (prod_p1),
        .sum      (sum),
        .overflow (add_ovf)
    );

    // Stage p2: accumulator and sticky overflow; clear only acts in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc           <= '0;
            overflow_flag <= 1'b0;
        end else if (state == IDLE && clear) begin
            acc           <= '0;
            overflow_flag <= 1'b0;
        end else if (state == ACCUM) begin
            acc           <= sum;
            overflow_flag <= overflow_flag | add_ovf | prod_ovf_p1;
        end
    end

endmodule

// File: tb/tb_mul_accumulate_seq.sv
// Directed bench for mul_accumulate_seq with a behavioural Booth multiplier
// and a queue of expected sums compared at each acc_valid pulse.
module tb_mul_accumulate_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_last;
    logic        clear;
    logic        mul_start;
    logic [15:0] mul_multiplicand;
    logic [15:0] mul_multiplier;
    logic [15:0] mul_result;
    logic        mul_overflow;
    logic        mul_finish;
    logic [15:0] acc_out;
    logic        acc_valid;
    logic        overflow_flag;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mul_accumulate_seq dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_a             (in_a),
        .in_b             (in_b),
        .in_last          (in_last),
        .clear            (clear),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_result       (mul_result),
        .mul_overflow     (mul_overflow),
        .mul_finish       (mul_finish),
        .acc_out          (acc_out),
        .acc_valid        (acc_valid),
        .overflow_flag    (overflow_flag),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Q8.7 multiply: full signed product, arithmetic shift by 7, flag if it
    // does not fit 16 bits. Result is the low 16 bits (wrapped).
    function automatic logic [16:0] mul_model(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] p;
        logic signed [31:0] q;
        logic               o;
        p = $signed(a) * $signed(b);
        q = p >>> 7;
        o = (q > 32767) || (q < -32768);
        return {o, q[15:0]};
    endfunction

    // Behavioural multiplier: finish falls fall_cfg cycles after start
    // (0 = at the start edge), rises with the product lat_cfg cycles after.
    int          fall_cfg = 0;
    int          lat_cfg  = 4;
    int          cnt;
    logic        pending;
    logic [15:0] op_a, op_b;
    int          unstable = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_finish   <= 1'b0;
            mul_result   <= '0;
            mul_overflow <= 1'b0;
            pending      <= 1'b0;
            cnt          <= 0;
        end else if (mul_start) begin
            op_a    <= mul_multiplicand;
            op_b    <= mul_multiplier;
            pending <= 1'b1;
            cnt     <= 1;
            if (fall_cfg == 0) mul_finish <= 1'b0;
        end else if (pending) begin
            if (cnt == fall_cfg) mul_finish <= 1'b0;
            if (cnt == lat_cfg) begin
                {mul_overflow, mul_result} <= mul_model(op_a, op_b);
                mul_finish <= 1'b1;
                pending    <= 1'b0;
            end
            if (mul_multiplicand !== op_a || mul_multiplier !== op_b) unstable <= unstable + 1;
            cnt <= cnt + 1;
        end
    end

    int          pulse_cnt = 0;
    logic [15:0] pulse_acc;
    logic        pulse_ovf;

    always @(negedge clk) begin
        if (acc_valid === 1'b1) begin
            pulse_cnt <= pulse_cnt + 1;
            pulse_acc <= acc_out;
            pulse_ovf <= overflow_flag;
        end
    end

    typedef struct {
        logic [15:0] acc;
        logic        flag;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] exp_acc  = '0;
    logic        exp_flag = 1'b0;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic model_term(input logic [15:0] a, input logic [15:0] b, input logic clr);
        logic [16:0] m;
        logic [15:0] p;
        logic [16:0] s;
        logic        ao;
        if (clr) begin
            exp_acc  = '0;
            exp_flag = 1'b0;
        end
        m = mul_model(a, b);
        p = m[15:0];
`ifdef MAC_SATURATE_EN
        if (m[16]) p = (a[15] ^ b[15]) ? 16'h8000 : 16'h7FFF;
`endif
        s  = {exp_acc[15], exp_acc} + {p[15], p};
        ao = s[16] ^ s[15];
`ifdef MAC_SATURATE_EN
        if (ao) exp_acc = s[16] ? 16'h8000 : 16'h7FFF;
        else    exp_acc = s[15:0];
`else
        exp_acc = s[15:0];
`endif
        exp_flag = exp_flag | m[16] | ao;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last,
                        input logic clr, input logic clr_busy);
        int   n;
        int   p0;
        exp_t e;
        wait_ready();
        p0       = pulse_cnt;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        clear    = clr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        clear    = clr_busy;
        model_term(a, b, clr);
        if (last) sbq.push_back('{acc: exp_acc, flag: exp_flag});
        if (clr_busy) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            clear = 1'b0;
        end
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_wait", {31'd0, busy}, 32'd0);
        chk("pulse_count", pulse_cnt - p0, last ? 32'd1 : 32'd0);
        if (last) begin
            chk("sb_nonempty", sbq.size(), 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_acc", {16'd0, pulse_acc}, {16'd0, e.acc});
                chk("sb_flag", {31'd0, pulse_ovf}, {31'd0, e.flag});
            end
        end
    endtask

    initial begin
        int p0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        in_last  = 1'b0;
        clear    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_acc", {16'd0, acc_out}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, acc_valid}, 32'd0);
        chk("rst_start", {31'd0, mul_start}, 32'd0);
        chk("rst_flag", {31'd0, overflow_flag}, 32'd0);
        chk("rst_opa", {16'd0, mul_multiplicand}, 32'h0);
        rst = 1'b1;
        #1;
        chk("first_ready", {31'd0, in_ready}, 32'd1);

        // single term 2.0 * 3.0
        send(16'h0100, 16'h0180, 1'b1, 1'b1, 1'b0);
        chk("single_acc", {16'd0, acc_out}, 32'h0300);
        chk("single_flag", {31'd0, overflow_flag}, 32'd0);

        // two terms; clear held while busy must be ignored
        send(16'h00C0, 16'h0100, 1'b0, 1'b1, 1'b1);
        chk("two_mid_acc", {16'd0, acc_out}, 32'h0180);
        send(16'h0100, 16'h0180, 1'b1, 1'b0, 1'b0);
        chk("two_acc", {16'd0, acc_out}, 32'h0480);

        // accumulate overflow
        send(16'h3200, 16'h0100, 1'b0, 1'b1, 1'b0);
        send(16'h3200, 16'h0100, 1'b1, 1'b0, 1'b0);
`ifdef MAC_SATURATE_EN
        chk("accovf_acc", {16'd0, acc_out}, 32'h7FFF);
`else
        chk("accovf_acc", {16'd0, acc_out}, 32'hC800);
`endif
        chk("accovf_flag", {31'd0, overflow_flag}, 32'd1);

        // multiplier overflow, then clear in IDLE
        send(16'h4000, 16'h0200, 1'b1, 1'b1, 1'b0);
`ifdef MAC_SATURATE_EN
        chk("mulovf_acc", {16'd0, acc_out}, 32'h7FFF);
`else
        chk("mulovf_acc", {16'd0, acc_out}, 32'h0000);
`endif
        chk("mulovf_flag", {31'd0, overflow_flag}, 32'd1);
        wait_ready();
        clear = 1'b1;
        @(posedge clk); #1;
        clear    = 1'b0;
        exp_acc  = '0;
        exp_flag = 1'b0;
        chk("clear_acc", {16'd0, acc_out}, 32'h0);
        chk("clear_flag", {31'd0, overflow_flag}, 32'd0);

        // stale finish: previous finish still high when next term issues
        send(16'h0100, 16'h0100, 1'b1, 1'b1, 1'b0);
        chk("pre_stale_finish", {31'd0, mul_finish}, 32'd1);
        fall_cfg = 3;
        lat_cfg  = 7;
        send(16'h0080, 16'h0200, 1'b1, 1'b1, 1'b0);
        chk("stale_acc", {16'd0, acc_out}, 32'h0200);
        fall_cfg = 0;
        lat_cfg  = 4;

        // reset while waiting for the product
        send(16'h0100, 16'h0180, 1'b0, 1'b1, 1'b0);
        lat_cfg = 30;
        wait_ready();
        in_valid = 1'b1;
        in_a     = 16'h0100;
        in_b     = 16'h0100;
        in_last  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        p0  = pulse_cnt;
        rst = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        chk("arst_acc", {16'd0, acc_out}, 32'h0);
        chk("arst_start", {31'd0, mul_start}, 32'd0);
        chk("arst_flag", {31'd0, overflow_flag}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_first_ready", {31'd0, in_ready}, 32'd1);
        repeat (35) @(posedge clk);
        #1;
        chk("arst_no_pulse", pulse_cnt - p0, 32'd0);
        exp_acc  = '0;
        exp_flag = 1'b0;
        lat_cfg  = 4;

        // term after reset accumulates onto zero
        send(16'h0100, 16'h0180, 1'b1, 1'b0, 1'b0);
        chk("post_rst_acc", {16'd0, acc_out}, 32'h0300);
        chk("operand_stable", unstable, 32'd0);
        chk("sb_drained", sbq.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
